// File: rtl/gate_pkg.sv
// Shared definitions for the gate_pipe slice.
//  - OP_W        : op-code width used on the gate_pipe operation select port
//  - gate_op_e   : bitwise operation encodings
//  - buf_state_e : occupancy states of the two-entry output buffer
package gate_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } gate_op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/gate_skid_buf.sv
// Two-entry (main + skid) output buffer with valid/ready on both sides.
// Sustains one transfer per cycle while the consumer is ready, and absorbs one extra
// entry when the consumer stalls so that in_ready can be a registered, state-only signal.
//  clk       in   clock, rising edge
//  rst_n     in   asynchronous active-low reset
//  in_valid  in   payload present on in_data
//  in_ready  out  buffer can accept this cycle (registered)
//  in_data   in   payload
//  out_valid out  main entry holds a payload
//  out_ready in   consumer accepts this cycle
//  out_data  out  main entry payload (stable while out_valid && !out_ready)
module gate_skid_buf #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  import gate_pkg::*;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             drain;

  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && drain) begin
          // Head leaves and the new result takes its place in the same cycle.
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = BUF_TWO;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready is low here, so only a drain can change anything.
        if (drain) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    // Precompute next-cycle readiness so in_ready is a pure flop output.
    in_ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/gate_pipe.sv
// Registered bitwise logic unit for two WIDTH-bit operands with valid/ready flow control.
// The result plus zero/all-ones flags are computed on the input side and captured into a
// two-entry output buffer, giving 1-cycle latency and full throughput under backpressure.
//  clk       in   clock, rising edge
//  rst_n     in   asynchronous active-low reset
//  in_valid  in   operands/op present
//  in_ready  out  block can accept this cycle (registered, state-only)
//  in_a      in   operand A
//  in_b      in   operand B
//  in_op     in   operation select (gate_op_e)
//  out_valid out  result present
//  out_ready in   consumer accepts this cycle
//  out_data  out  result
//  out_zero  out  out_data == 0
//  out_ones  out  out_data == all ones
module gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = gate_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones
);

  import gate_pkg::*;

  localparam int unsigned PayW = WIDTH + 2;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input gate_op_e         op);
    logic [WIDTH-1:0] res;
    case (op)
      OP_AND:    res = a & b;
      OP_OR:     res = a | b;
      OP_XOR:    res = a ^ b;
      OP_NAND:   res = ~(a & b);
      OP_NOR:    res = ~(a | b);
      OP_XNOR:   res = ~(a ^ b);
      OP_PASS_A: res = a;
      default:   res = ~a;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_ones;
  logic [PayW-1:0]  pay_in;
  logic [PayW-1:0]  pay_out;

  always_comb begin
    res      = gate_eval(in_a, in_b, gate_op_e'(in_op));
    res_zero = (res == '0);
    res_ones = (res == '1);
    pay_in   = {res_ones, res_zero, res};
  end

  gate_skid_buf #(
    .WIDTH (PayW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign out_data = pay_out[WIDTH-1:0];
  assign out_zero = pay_out[WIDTH];
  assign out_ones = pay_out[WIDTH+1];

endmodule

// File: tb/tb_gate_pipe.sv
module tb_gate_pipe;

  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_ones8;
  logic [7:0] in_a8, in_b8, out_data8;
  logic [2:0] in_op8;

  // WIDTH=1 and WIDTH=32 instances share handshake drive
  logic        rv, rr;
  logic [2:0]  op6;
  logic        in_ready1, out_valid1, out_zero1, out_ones1;
  logic        in_a1, in_b1, out_data1;
  logic        in_ready32, out_valid32, out_zero32, out_ones32;
  logic [31:0] in_a32, in_b32, out_data32;

  gate_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_zero(out_zero8), .out_ones(out_ones8)
  );

  gate_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_op(op6), .out_valid(out_valid1),
    .out_ready(rr), .out_data(out_data1), .out_zero(out_zero1), .out_ones(out_ones1)
  );

  gate_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(in_ready32),
    .in_a(in_a32), .in_b(in_b32), .in_op(op6), .out_valid(out_valid32),
    .out_ready(rr), .out_data(out_data32), .out_zero(out_zero32), .out_ones(out_ones32)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  logic [7:0]  t2_exp [8];
  logic [7:0]  t4_a [4];
  logic [7:0]  t4_b [4];
  logic [7:0]  t4_exp [4];
  int          idx;
  logic        acc_now;
  int          n_out;
  logic        ready_drop;

  logic [2:0]  q1 [$];
  logic [33:0] q32 [$];
  logic [2:0]  prev1, e1;
  logic [33:0] prev32, e32;
  logic        stall1, stall32, hold;
  logic [31:0] tmp;
  int          acc6, cycles;

  initial begin
    t2_exp = '{8'hA0, 8'hFA, 8'h5A, 8'h5F, 8'h05, 8'hA5, 8'hF0, 8'h0F};
    t4_a   = '{8'h12, 8'hFF, 8'hA5, 8'h00};
    t4_b   = '{8'h34, 8'h0F, 8'h5A, 8'h00};
    t4_exp = '{8'h26, 8'hF0, 8'hFF, 8'h00};

    rst_n = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_op8 = '0; out_ready8 = 1'b0;
    rv = 1'b0; rr = 1'b0; op6 = '0; in_a1 = 1'b0; in_b1 = 1'b0; in_a32 = '0; in_b32 = '0;
    #12 rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_in_ready", 64'(in_ready8), 64'd1);
    check("rst_out_data", 64'(out_data8), 64'd0);
    cyc();

    // 1. Async reset with two entries buffered
    in_valid8 = 1'b1; in_a8 = 8'h11; in_b8 = 8'h22; in_op8 = 3'd2;
    cyc(); cyc();
    in_valid8 = 1'b0;
    check("t1_full_in_ready", 64'(in_ready8), 64'd0);
    check("t1_full_out_valid", 64'(out_valid8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_out_valid", 64'(out_valid8), 64'd0);
    check("t1_rst_out_data", 64'(out_data8), 64'd0);
    check("t1_rst_flags", 64'({out_ones8, out_zero8}), 64'd0);
    check("t1_rst_in_ready", 64'(in_ready8), 64'd1);
    #1 rst_n = 1'b1;
    cyc();
    check("t1_post_out_valid", 64'(out_valid8), 64'd0);

    // 2. Op sweep
    out_ready8 = 1'b1;
    for (int op = 0; op < 8; op++) begin
      in_valid8 = 1'b1; in_a8 = 8'hF0; in_b8 = 8'hAA; in_op8 = 3'(op);
      cyc();
      check($sformatf("t2_valid_op%0d", op), 64'(out_valid8), 64'd1);
      check($sformatf("t2_data_op%0d", op), 64'(out_data8), 64'(t2_exp[op]));
    end
    in_valid8 = 1'b0;
    cyc();
    check("t2_idle_valid", 64'(out_valid8), 64'd0);

    // 3. Flags
    in_valid8 = 1'b1; in_a8 = 8'h0F; in_b8 = 8'hF0; in_op8 = 3'd0;
    cyc();
    check("t3_and_data", 64'(out_data8), 64'h00);
    check("t3_and_zero", 64'(out_zero8), 64'd1);
    check("t3_and_ones", 64'(out_ones8), 64'd0);
    in_op8 = 3'd1;
    cyc();
    check("t3_or_data", 64'(out_data8), 64'hFF);
    check("t3_or_ones", 64'(out_ones8), 64'd1);
    check("t3_or_zero", 64'(out_zero8), 64'd0);
    in_valid8 = 1'b0;
    cyc();

    // 4. Backpressure
    out_ready8 = 1'b0;
    idx = 0;
    repeat (4) begin
      in_valid8 = 1'b1; in_a8 = t4_a[idx]; in_b8 = t4_b[idx]; in_op8 = 3'd2;
      acc_now = in_ready8;
      cyc();
      if (acc_now) idx++;
    end
    in_valid8 = 1'b0;
    check("t4_accepted", 64'(idx), 64'd2);
    check("t4_in_ready", 64'(in_ready8), 64'd0);
    out_ready8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t4_valid%0d", k), 64'(out_valid8), 64'd1);
      check($sformatf("t4_data%0d", k), 64'(out_data8), 64'(t4_exp[k]));
      cyc();
    end
    check("t4_drained", 64'(out_valid8), 64'd0);
    for (int k = 2; k < 4; k++) begin
      in_valid8 = 1'b1; in_a8 = t4_a[k]; in_b8 = t4_b[k]; in_op8 = 3'd2;
      cyc();
      check($sformatf("t4_data%0d", k), 64'(out_data8), 64'(t4_exp[k]));
    end
    in_valid8 = 1'b0;
    cyc();

    // 5. Accept + drain in ONE
    n_out = 0; ready_drop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid8 = 1'b1; in_a8 = 8'(i + 3); in_b8 = 8'h00; in_op8 = 3'd6;
      if (!in_ready8) ready_drop = 1'b1;
      cyc();
      if (out_valid8) begin
        check($sformatf("t5_data%0d", i), 64'(out_data8), 64'(i + 3));
        n_out++;
      end
    end
    in_valid8 = 1'b0;
    check("t5_count", 64'(n_out), 64'd10);
    check("t5_ready_drop", 64'(ready_drop), 64'd0);
    cyc();

    // 6. Random handshakes, WIDTH=1 and WIDTH=32
    acc6 = 0; cycles = 0; hold = 1'b0; stall1 = 1'b0; stall32 = 1'b0;
    while (acc6 < 1000 && cycles < 20000) begin
      if (!hold) begin
        rv = ($urandom_range(0, 3) != 0);
        op6 = 3'($urandom_range(0, 7));
        in_a1 = 1'($urandom); in_b1 = 1'($urandom);
        in_a32 = $urandom; in_b32 = $urandom;
      end
      rr = ($urandom_range(0, 2) != 0);
      if (stall1) begin
        check("t6_w1_stable", 64'({out_valid1, out_ones1, out_zero1, out_data1}),
              64'({1'b1, prev1}));
      end
      if (stall32) begin
        check("t6_w32_stable", 64'({out_valid32, out_ones32, out_zero32, out_data32}),
              64'({1'b1, prev32}));
      end
      if (out_valid1 && rr) begin
        if (q1.size() == 0) check("t6_w1_extra", 64'd1, 64'd0);
        else check("t6_w1_data", 64'({out_ones1, out_zero1, out_data1}), 64'(q1.pop_front()));
      end
      if (out_valid32 && rr) begin
        if (q32.size() == 0) check("t6_w32_extra", 64'd1, 64'd0);
        else check("t6_w32_data", 64'({out_ones32, out_zero32, out_data32}),
                   64'(q32.pop_front()));
      end
      stall1  = out_valid1 && !rr;
      stall32 = out_valid32 && !rr;
      prev1   = {out_ones1, out_zero1, out_data1};
      prev32  = {out_ones32, out_zero32, out_data32};
      if (rv && in_ready1) begin
        tmp = ref_op({31'd0, in_a1}, {31'd0, in_b1}, op6);
        e1  = {tmp[0] == 1'b1, tmp[0] == 1'b0, tmp[0]};
        q1.push_back(e1);
      end
      if (rv && in_ready32) begin
        tmp = ref_op(in_a32, in_b32, op6);
        e32 = {tmp == 32'hFFFF_FFFF, tmp == 32'd0, tmp};
        q32.push_back(e32);
        acc6++;
      end
      hold = rv && !in_ready32;
      cyc();
      cycles++;
    end
    check("t6_accepted", 64'(acc6), 64'd1000);
    rv = 1'b0; rr = 1'b1;
    repeat (6) begin
      if (out_valid1) begin
        if (q1.size() == 0) check("t6_w1_extra", 64'd1, 64'd0);
        else check("t6_w1_data", 64'({out_ones1, out_zero1, out_data1}), 64'(q1.pop_front()));
      end
      if (out_valid32) begin
        if (q32.size() == 0) check("t6_w32_extra", 64'd1, 64'd0);
        else check("t6_w32_data", 64'({out_ones32, out_zero32, out_data32}),
                   64'(q32.pop_front()));
      end
      cyc();
    end
    check("t6_w1_left", 64'(q1.size()), 64'd0);
    check("t6_w32_left", 64'(q32.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
